// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//
// Purpose:
//   Shared definitions for the register-file writeback arbiter slice.
//   Holds the register-file geometry, the FSM state encoding, the requester
//   port indices, and a small struct/helper used to carry a selected write.
//
// Contents:
//   NUM_REGS, REG_ID_W, DATA_W  register-file geometry
//   INIT, RUN                   FSM state encoding (1 bit)
//   PORT_ALU, PORT_MEM          requester indices into valid/grant vectors
//   INIT_LAST                   last sweep pointer value, sized for initPtr
//   wbWrite_t                   destination register + data pair
//   pickWrite()                 selects the granted requester's pair
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_ID_W = $clog2(NUM_REGS);
    localparam int DATA_W   = 16;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int PORT_ALU = 0;
    localparam int PORT_MEM = 1;

    // The sweep pointer is one bit wider than a register index so the
    // terminal comparison never has to rely on wrap-around.
    localparam logic [REG_ID_W:0] INIT_LAST = (REG_ID_W+1)'(NUM_REGS - 1);

    typedef struct packed {
        logic [REG_ID_W-1:0] dst;
        logic [DATA_W-1:0]   data;
    } wbWrite_t;

    // Returns the write carried by the MEM port when it holds the grant,
    // otherwise the ALU port's write. Only meaningful when a grant exists.
    function automatic wbWrite_t pickWrite(
        input logic                memGranted,
        input logic [REG_ID_W-1:0] aluReg,
        input logic [DATA_W-1:0]   aluData,
        input logic [REG_ID_W-1:0] memReg,
        input logic [DATA_W-1:0]   memData
    );
        wbWrite_t w;
        if (memGranted) begin
            w.dst  = memReg;
            w.data = memData;
        end else begin
            w.dst  = aluReg;
            w.data = aluData;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//
// Purpose:
//   Two-way round-robin arbiter, purely combinational. A lone requester is
//   always granted; when both request, the port that did not win most
//   recently is granted. At most one grant bit is ever high.
//
// Ports:
//   valid [1:0]  in   request vector, index PORT_ALU / PORT_MEM
//   last         in   index of the port that won the previous transfer
//   grant [1:0]  out  one-hot (or zero) grant vector
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // The ALU wins if it is alone, or if both request and the MEM port
    // was the previous winner; the MEM port wins symmetrically.
    always_comb begin
        grant = 2'b00;
        grant[PORT_ALU] = valid[PORT_ALU] & (~valid[PORT_MEM] | last);
        grant[PORT_MEM] = valid[PORT_MEM] & (~valid[PORT_ALU] | ~last);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single write port of the 16x16 register file. After reset it
//   sweeps zero into every register, then shares the write port between
//   the ALU (port 0) and MEM (port 1) writeback requesters with round-robin
//   arbitration and a valid/ready handshake. All write-port outputs are
//   registered; an accept in cycle t shows up on the write port in t+1.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/reg/data       ALU writeback request
//   req0_ready                ALU accepted this cycle (combinational)
//   req1_valid/reg/data       MEM writeback request
//   req1_ready                MEM accepted this cycle (combinational)
//   rf_write_reg              register-file WriteReg
//   rf_dst_reg                register-file DstReg
//   rf_dst_data               register-file DstData
//   init_done                 high once the zero sweep has completed
//
// Configuration:
//   REGFILE_WB_ARB_R0_DISCARD_EN  when defined, accepted writes to R0 are
//   dropped after the sweep: no write strobe, and DstReg/DstData keep their
//   previous values so the bypass can never present non-zero data for R0.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [REG_ID_W-1:0] req0_reg,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [REG_ID_W-1:0] req1_reg,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    output logic                rf_write_reg,
    output logic [REG_ID_W-1:0] rf_dst_reg,
    output logic [DATA_W-1:0]   rf_dst_data,
    output logic                init_done
);

    logic [0:0]          state;
    logic [REG_ID_W:0]   initPtr;
    logic                rrLast;
    logic [1:0]          validRun;
    logic [1:0]          grant;
    logic                transfer;
    logic                discardR0;
    wbWrite_t            selWrite;

    // Requests are invisible to the arbiter during the sweep, which keeps
    // both ready outputs low until the register file has been cleared.
    always_comb begin
        validRun = 2'b00;
        if (state == RUN) begin
            validRun[PORT_ALU] = req0_valid;
            validRun[PORT_MEM] = req1_valid;
        end
    end

    rr_arbiter_2 arbiter (
        .valid (validRun),
        .last  (rrLast),
        .grant (grant)
    );

    assign req0_ready = grant[PORT_ALU];
    assign req1_ready = grant[PORT_MEM];
    assign transfer   = |grant;

    // The selected pair is only consumed when a transfer happens, so the
    // fallback to the ALU port when nothing is granted is harmless.
    assign selWrite = pickWrite(grant[PORT_MEM], req0_reg, req0_data,
                                req1_reg, req1_data);

    // An R0 write is still handshaken normally (the requester must see it
    // retire) but never reaches the write port when discard is enabled.
`ifdef REGFILE_WB_ARB_R0_DISCARD_EN
    assign discardR0 = (selWrite.dst == '0);
`else
    assign discardR0 = 1'b0;
`endif

    // init_done mirrors the FSM state; it is a flop output by construction.
    assign init_done = (state == RUN);

    // Sweep and writeback sequencing. In INIT the output registers walk
    // through every register with zero data. In RUN they either capture
    // the granted write or drop the strobe while holding DstReg/DstData:
    // the register file bypasses on DstReg without looking at WriteReg,
    // and the held pair always matches what was last committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            initPtr      <= '0;
            rrLast       <= 1'b1;
            rf_write_reg <= 1'b0;
            rf_dst_reg   <= '0;
            rf_dst_data  <= '0;
        end else if (state == INIT) begin
            rf_write_reg <= 1'b1;
            rf_dst_reg   <= initPtr[REG_ID_W-1:0];
            rf_dst_data  <= '0;
            initPtr      <= initPtr + 1'b1;
            if (initPtr == INIT_LAST) begin
                state <= RUN;
            end
        end else begin
            if (transfer) begin
                rrLast <= grant[PORT_MEM];
                if (discardR0) begin
                    rf_write_reg <= 1'b0;
                end else begin
                    rf_write_reg <= 1'b1;
                    rf_dst_reg   <= selWrite.dst;
                    rf_dst_data  <= selWrite.data;
                end
            end else begin
                rf_write_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 16x16 register file (DstReg/WriteReg/DstData).
- After reset, runs a zero-initialisation sweep of every register.
- Then shares the write port between two writeback requesters, ALU (port 0) and MEM (port 1), using round-robin arbitration and a valid/ready handshake.
- All write-port outputs are registered; the block sits between the writeback stage and the register file.

Parameters:
- NUM_REGS, 16, number of architectural registers (power of two).
- REG_ID_W, 4, register index width, log2(NUM_REGS).
- DATA_W, 16, register data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU requester has a write pending.
- req0_reg  in  REG_ID_W  ALU destination register.
- req0_data  in  DATA_W  ALU write data.
- req0_ready  out  1  ALU request accepted this cycle (combinational).
- req1_valid  in  1  MEM requester has a write pending.
- req1_reg  in  REG_ID_W  MEM destination register.
- req1_data  in  DATA_W  MEM write data.
- req1_ready  out  1  MEM request accepted this cycle (combinational).
- rf_write_reg  out  1  drives register-file WriteReg.
- rf_dst_reg  out  REG_ID_W  drives register-file DstReg.
- rf_dst_data  out  DATA_W  drives register-file DstData.
- init_done  out  1  high once the init sweep has completed.

Behaviour:
- Reset (rst high at an edge):
  - state=INIT, init_ptr=0, rr_last=1 (port 0 has priority first).
  - rf_write_reg=0, rf_dst_reg=0, rf_dst_data=0, init_done=0.
  - Both ready outputs are 0 throughout INIT.
- INIT state:
  - On each edge, output registers load (1, init_ptr, 0) and init_ptr increments.
  - After the edge that loads init_ptr=NUM_REGS-1, state becomes RUN and init_done becomes 1.
  - rf_write_reg is therefore high for exactly NUM_REGS consecutive cycles, with rf_dst_reg=0,1,...,15.
- RUN state, arbitration (combinational):
  - Only one valid: that port is granted.
  - Both valid: grant the port that is not rr_last.
  - readyN = grantN. A transfer occurs when validN && readyN.
  - At most one transfer per cycle; the loser's ready stays 0.
- RUN state, transfer:
  - At the next edge the output registers load (1, reqN_reg, reqN_data) and rr_last=N.
  - Latency: accept at cycle t, rf_write_reg high in cycle t+1; the register file commits at the t+1→t+2 edge.
- RUN state, no transfer:
  - rf_write_reg=0 at the next edge.
  - rf_dst_reg and rf_dst_data hold their last values. This is required: the register file's read bypass compares DstReg against SrcReg without qualifying on WriteReg. The held pair always equals committed contents, so a spurious bypass returns the correct value.
- Requester rules:
  - Requesters must hold valid, reg and data stable until accepted.
  - valid must not depend combinationally on ready.
- Reset mid-operation (including mid-INIT):
  - The sweep restarts at register 0 and init_done drops.
  - A write already registered is dropped: rf_write_reg=0 in the cycle after the reset edge.
- init_ptr arithmetic: width REG_ID_W+1, no wrap inside INIT.

Optional Feature:
- Macro: REGFILE_WB_ARB_R0_DISCARD_EN.
- Defined:
  - A RUN-state request with reqN_reg==0 is still accepted (ready as normal) and rr_last still updates.
  - rf_write_reg=0 at the next edge.
  - rf_dst_reg and rf_dst_data hold their previous values; they are not loaded with the discarded pair, so no bypass of non-zero data for R0 can occur.
  - The INIT sweep still writes R0.
- Undefined: register 0 is written like any other register.

Decomposition:
- Shared package holds:
  - Constants NUM_REGS, REG_ID_W, DATA_W.
  - State encoding INIT=1'b0, RUN=1'b1.
  - Port indices ALU=0, MEM=1.
- One sub-module: rr_arbiter_2 (inputs valid[1:0] and last; output grant[1:0]), purely combinational.
- The FSM and output registers live in the top module.

Test Plan:
- Reset 3 cycles, then release → rf_write_reg high for 16 cycles with rf_dst_reg 0..15 and data 0; init_done rises on the 17th cycle; ready=0 throughout.
- RUN: req0 (r3, 16'hABCD) alone → req0_ready=1 same cycle; next cycle rf_write_reg=1, rf_dst_reg=3, rf_dst_data=16'hABCD; the cycle after, rf_write_reg=0 with reg/data held.
- Both valid for 4 cycles (req0 r1/16'h0001, req1 r2/16'h0002) → grants alternate 0,1,0,1; each loser keeps its request; both complete.
- rst asserted at sweep cycle 7 → rf_write_reg=0 on the next cycle, then the sweep restarts at rf_dst_reg=0; init_done stays 0 until 16 fresh writes.
- With REGFILE_WB_ARB_R0_DISCARD_EN: write r5/16'h1234, then r0/16'hFFFF → r0 accepted; rf_write_reg=0; rf_dst_reg=5 and rf_dst_data=16'h1234 held. Without the macro → rf_dst_reg=0, rf_dst_data=16'hFFFF written.
- Idle after a write to r7/16'h00AA → register-file read of r7 returns 16'h00AA, both via the bypass and after commit.
